exp_x: RTL and testbench

//  Iterative hyperbolic CORDIC (rotation mode) computing e^x = cosh(x)+sinh(x).

---
 rtl/exp_x.sv | 157 +++++++++++++++
 tb/tb_exp_x.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exp_x.sv
// Iterative hyperbolic CORDIC (rotation mode) producing e^x = cosh(x) + sinh(x).
// Q2.14 in/out, one micro-rotation per clock, start/done handshake.
module exp_x #(
    parameter int unsigned N_ITER = 15,
    parameter int unsigned GUARD  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st,
    input  logic [15:0] x,
    output logic [15:0] result,
    output logic        done,
    output logic        busy,
    output logic        err
);

    localparam int unsigned XW      = 16;
    localparam int unsigned W       = XW + GUARD + 1;
    localparam int unsigned FRAC    = 14 + GUARD;
    localparam int unsigned N_STEPS = N_ITER + ((N_ITER >= 4) ? 1 : 0) + ((N_ITER >= 13) ? 1 : 0);
    localparam int unsigned CW      = $clog2(N_STEPS);

    localparam logic signed [W-1:0] X_INIT = W'(19784 * (2 ** GUARD));
    localparam logic signed [W-1:0] Z_ONE  = W'(2 ** FRAC);
    localparam logic [CW-1:0]       LAST   = CW'(N_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t state, state_next;

    logic signed [W-1:0] xr, yr, zr;
    logic [CW-1:0]       cnt;

    // Step number -> hyperbolic index; indices 4 and 13 are repeated for convergence.
    function automatic logic [CW-1:0] iter_index(input logic [CW-1:0] s);
        int unsigned i;
        i = 32'(s) + 1;
        if (32'(s) >= 4)  i = i - 1;
        if (32'(s) >= 14) i = i - 1;
        return CW'(i);
    endfunction

    // atanh(2^-i) in Q2.18, truncated; beyond i=7 it equals 2^-i to within a fraction of an LSB.
    function automatic logic signed [W-1:0] atanh_lut(input logic [CW-1:0] i);
        logic signed [W-1:0] v;
        case (32'(i))
            1:       v = W'(143997);
            2:       v = W'(66954);
            3:       v = W'(32940);
            4:       v = W'(16405);
            5:       v = W'(8194);
            6:       v = W'(4096);
            7:       v = W'(2048);
            default: v = Z_ONE >>> i;
        endcase
        return v;
    endfunction

    logic [CW-1:0]       sh;
    logic                d_pos;
    logic signed [W-1:0] xs, ys, ang;
    logic signed [W-1:0] x_nx, y_nx, z_nx, sum_nx;
    logic signed [15:0]  xin;
    logic                in_range;

    // One micro-rotation datapath.
    always_comb begin
        sh     = iter_index(cnt);
        d_pos  = ~zr[W-1];
        xs     = xr >>> sh;
        ys     = yr >>> sh;
        ang    = atanh_lut(sh);
        x_nx   = d_pos ? (xr + ys) : (xr - ys);
        y_nx   = d_pos ? (yr + xs) : (yr - xs);
        z_nx   = d_pos ? (zr - ang) : (zr + ang);
        sum_nx = x_nx + y_nx;
    end

    assign xin      = $signed(x);
    assign in_range = (xin >= -16'sd16384) && (xin <= 16'sd16384);

    logic load, step, fin, reject;

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        fin        = 1'b0;
        reject     = 1'b0;
        case (state)
            S_IDLE: begin
                if (st) begin
                    if (in_range) begin
                        load       = 1'b1;
                        state_next = S_RUN;
                    end else begin
                        reject     = 1'b1;
                        state_next = S_FIN;
                    end
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    fin        = 1'b1;
                    state_next = S_FIN;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            xr     <= '0;
            yr     <= '0;
            zr     <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == S_FIN);
            busy  <= (state_next == S_RUN);
            if (load) begin
                xr  <= X_INIT;
                yr  <= '0;
                zr  <= W'(xin) <<< GUARD;
                cnt <= '0;
                err <= 1'b0;
            end
            if (step) begin
                xr  <= x_nx;
                yr  <= y_nx;
                zr  <= z_nx;
                cnt <= cnt + CW'(1);
            end
            if (fin) begin
                result <= 16'(sum_nx >>> GUARD);
            end
            if (reject) begin
                err    <= 1'b1;
                result <= '0;
            end
        end
    end

endmodule

// File: tb/tb_exp_x.sv
// Self-checking bench for exp_x: directed corner cases plus randomized operands
// compared against a real-valued exponential reference.
module tb_exp_x;

    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [15:0] x;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    exp_x dut (
        .clk    (clk),
        .rst    (rst),
        .st     (st),
        .x      (x),
        .result (result),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
        int d;
        d = obs - expv;
        checks++;
        assert (((d <= tol) && (d >= -tol)) === 1'b1) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h +/- %0d", tag, obs, expv, tol);
        end
    endtask

    function automatic int model_exp(input logic [15:0] xv);
        real r;
        r = $itor($signed(xv)) / 16384.0;
        return $rtoi($floor($exp(r) * 16384.0 + 0.5));
    endfunction

    // Issue one operation and count clock edges from the start edge until done.
    task automatic run_op(input logic [15:0] xv, output logic [15:0] res,
                          output logic e, output int lat);
        @(negedge clk);
        x  = xv;
        st = 1'b1;
        @(posedge clk);
        #1;
        st  = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_seen", int'(lat < 40), 1);
        res = result;
        e   = err;
        @(posedge clk);
        #1;
        chk("done_pulse_width", int'(done), 0);
    endtask

    initial begin
        logic [15:0] res;
        logic        e;
        int          lat;
        int          seen;
        logic [15:0] xv;

        rst = 1'b1;
        st  = 1'b0;
        x   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", int'(result), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        // e^0
        run_op(16'h0000, res, e, lat);
        chk("zero_latency", lat, 17);
        chk_tol("zero_result", int'(res), 16'h4000, 4);
        chk("zero_err", int'(e), 0);

        // Range endpoints
        run_op(16'h4000, res, e, lat);
        chk_tol("plus_one", int'(res), 16'hADF8, 4);
        chk("plus_one_err", int'(e), 0);
        run_op(16'hC000, res, e, lat);
        chk_tol("minus_one", int'(res), 16'h178B, 4);
        chk("minus_one_latency", lat, 17);

        // Just outside the range
        run_op(16'h4001, res, e, lat);
        chk("oor_hi_fast", int'(lat <= 1), 1);
        chk("oor_hi_err", int'(e), 1);
        chk("oor_hi_result", int'(res), 0);
        run_op(16'hBFFF, res, e, lat);
        chk("oor_lo_fast", int'(lat <= 1), 1);
        chk("oor_lo_err", int'(e), 1);
        chk("oor_lo_result", int'(res), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_held", int'(err), 1);

        // Second start during RUN is ignored
        @(negedge clk);
        x  = 16'h0000;
        st = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        chk("busy_in_run", int'(busy), 1);
        chk("err_cleared_on_start", int'(err), 0);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 5) begin
                x  = 16'h4000;
                st = 1'b1;
            end else begin
                st = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        st = 1'b0;
        chk("ignore_st_latency", lat, 17);
        chk_tol("ignore_st_result", int'(result), 16'h4000, 4);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        chk("ignore_st_no_requeue", seen, 0);

        // Reset in the middle of an operation
        @(negedge clk);
        x  = 16'h2000;
        st = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_result", int'(result), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err", int'(err), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        chk("midrst_no_done", seen, 0);
        run_op(16'h2000, res, e, lat);
        chk("after_rst_latency", lat, 17);
        chk_tol("after_rst_result", int'(res), model_exp(16'h2000), 4);

        // Round trip: feed ln(v) and expect v back
        for (int v = 16'h1800; v <= 16'h8000; v += 16'h0400) begin
            real lv;
            lv = $ln($itor(v) / 16384.0) * 16384.0;
            xv = 16'($rtoi($floor(lv + 0.5)));
            run_op(xv, res, e, lat);
            chk_tol("round_trip", int'(res), v, 8);
        end

        // Random in-range operands against the real-valued model
        for (int n = 0; n < 300; n++) begin
            xv = 16'(int'($urandom_range(0, 32768)) - 16384);
            run_op(xv, res, e, lat);
            chk_tol("random", int'(res), model_exp(xv), 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
